// File: rtl/sharpen_filter.sv
// rtl/sharpen_filter.sv - in-place 3x3 sharpen of the grayscale image using three rotating line buffers
module sharpen_filter #(
    parameter int DIM  = 64,
    parameter int PIXW = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] in_pix,
    output logic [5:0]  row,
    output logic [5:0]  col,
    output logic        out_we,
    output logic [23:0] out_pix,
    output logic        filter_done
);

    localparam logic [5:0] LAST = 6'(DIM - 1);
    localparam int SW = PIXW + 4;
    localparam int AW = PIXW + 5;
    localparam logic signed [AW-1:0] PMAX = AW'((1 << PIXW) - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t            state, state_n;
    logic [5:0]        row_n, col_n;
    logic              we_n, done_n;
    logic [23:0]       pix_n;
    logic [PIXW-1:0]   lbuf [3][DIM];

    logic [5:0]        k_row, k_col;
    logic [PIXW-1:0]   center, g_val;
    logic [SW-1:0]     nsum, c9;
    logic signed [AW-1:0] acc;
    logic [23:0]       kpix;
    logic              unused_rb;

    assign unused_rb = ^{in_pix[23:16], in_pix[7:0]};

    function automatic logic [1:0] slot_of(input logic [5:0] r);
        return 2'(r % 6'd3);
    endfunction

    // d: 0 = previous, 1 = same, 2 = next row/column; off-image taps read as zero
    function automatic logic tap_ok(input logic [5:0] pos, input int d);
        if (d == 0) return pos != 6'd0;
        if (d == 2) return pos != LAST;
        return 1'b1;
    endfunction

    // The kernel always evaluates the pixel whose address is about to be registered
    always_comb begin
        k_row = 6'd0;
        k_col = 6'd0;
        if (state == LOAD) begin
            k_row = row - 6'd1;
        end else if (state == WRITE) begin
            if (col == LAST) begin
                k_row = row + 6'd1;
            end else begin
                k_row = row;
                k_col = col + 6'd1;
            end
        end
    end

    always_comb begin
        nsum = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                if (!(dr == 1 && dc == 1) && tap_ok(k_row, dr) && tap_ok(k_col, dc)) begin
                    nsum = nsum + SW'(lbuf[slot_of(6'(k_row + 6'(dr) - 6'd1))][6'(k_col + 6'(dc) - 6'd1)]);
                end
            end
        end
        center = lbuf[slot_of(k_row)][k_col];
        c9     = SW'({center, 3'b000}) + SW'(center);
        acc    = $signed({1'b0, c9}) - $signed({1'b0, nsum});
        if (acc < 0) begin
            g_val = '0;
        end else if (acc > PMAX) begin
            g_val = '1;
        end else begin
            g_val = acc[PIXW-1:0];
        end
        kpix = {{PIXW{1'b0}}, g_val, {PIXW{1'b0}}};
    end

    always_comb begin
        state_n = state;
        row_n   = row;
        col_n   = col;
        we_n    = 1'b0;
        pix_n   = '0;
        done_n  = filter_done;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = LOAD;
                    row_n   = 6'd0;
                    col_n   = 6'd0;
                end
            end
            LOAD: begin
                if (col == LAST) begin
                    col_n = 6'd0;
                    if (row == 6'd0) begin
                        row_n = 6'd1;
                    end else begin
                        state_n = WRITE;
                        row_n   = row - 6'd1;
                        we_n    = 1'b1;
                        pix_n   = kpix;
                    end
                end else begin
                    col_n = col + 6'd1;
                end
            end
            WRITE: begin
                if (col != LAST) begin
                    col_n = col + 6'd1;
                    we_n  = 1'b1;
                    pix_n = kpix;
                end else if (row == LAST) begin
                    state_n = DONE;
                    row_n   = 6'd0;
                    col_n   = 6'd0;
                    done_n  = 1'b1;
                end else if (row == LAST - 6'd1) begin
                    row_n = LAST;
                    col_n = 6'd0;
                    we_n  = 1'b1;
                    pix_n = kpix;
                end else begin
                    state_n = LOAD;
                    row_n   = row + 6'd2;
                    col_n   = 6'd0;
                end
            end
            DONE: begin
                row_n  = 6'd0;
                col_n  = 6'd0;
                done_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            row         <= 6'd0;
            col         <= 6'd0;
            out_we      <= 1'b0;
            out_pix     <= '0;
            filter_done <= 1'b0;
        end else begin
            state       <= state_n;
            row         <= row_n;
            col         <= col_n;
            out_we      <= we_n;
            out_pix     <= pix_n;
            filter_done <= done_n;
        end
    end

    // Row r lands in slot r mod 3, overwriting row r-3 which is no longer needed
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            lbuf[slot_of(row)][col] <= in_pix[2*PIXW-1:PIXW];
        end
    end

endmodule

// File: tb/tb_sharpen_filter.sv
// tb/tb_sharpen_filter.sv - randomized self-checking bench for sharpen_filter against an arithmetic kernel model
module tb_sharpen_filter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [23:0] in_pix;
    logic [5:0]  row, col;
    logic        out_we;
    logic [23:0] out_pix;
    logic        filter_done;

    logic [23:0] img [64][64];
    logic [23:0] src [64][64];
    int          pcnt [64][64];
    int          nwr = 0;
    logic        load_now;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sharpen_filter #(.DIM(64), .PIXW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_pix(in_pix),
        .row(row), .col(col), .out_we(out_we), .out_pix(out_pix),
        .filter_done(filter_done)
    );

    assign in_pix = img[row][col];

    always @(posedge clk) begin
        if (load_now) begin
            for (int r = 0; r < 64; r++) begin
                for (int c = 0; c < 64; c++) begin
                    img[r][c]  <= src[r][c];
                    pcnt[r][c] <= 0;
                end
            end
            nwr <= 0;
        end else if (out_we) begin
            img[row][col]  <= out_pix;
            pcnt[row][col] <= pcnt[row][col] + 1;
            nwr            <= nwr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int gat(input int r, input int c);
        if (r < 0 || r > 63 || c < 0 || c > 63) return 0;
        return int'(src[r][c][15:8]);
    endfunction

    function automatic logic [23:0] expect_px(input int r, input int c);
        int s;
        s = 9 * gat(r, c);
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (dr != 0 || dc != 0) s = s - gat(r + dr, c + dc);
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return {8'h00, 8'(s), 8'h00};
    endfunction

    task automatic fill_uniform(input logic [7:0] g);
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                src[r][c] = {8'($urandom), g, 8'($urandom)};
    endtask

    task automatic fill_random();
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                src[r][c] = 24'($urandom);
    endtask

    task automatic load_image();
        load_now = 1'b1;
        @(negedge clk);
        load_now = 1'b0;
    endtask

    task automatic do_reset();
        start = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_and_check(input string name);
        int bad;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 8192; k++) begin
            @(negedge clk);
            if (k == 8191) chk({name, "_done_early"}, 32'(filter_done), 32'd0);
            if (k == 8192) chk({name, "_done_on_time"}, 32'(filter_done), 32'd1);
        end
        chk({name, "_write_count"}, 32'(nwr), 32'd4096);
        bad = 0;
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                if (pcnt[r][c] != 1) bad++;
        chk({name, "_written_once"}, 32'(bad), 32'd0);
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                chk($sformatf("%s_px_%0d_%0d", name, r, c), 32'(img[r][c]), 32'(expect_px(r, c)));
    endtask

    initial begin
        int n0;
        rst_n = 1'b0;
        start = 1'b0;
        load_now = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_row", 32'(row), 32'd0);
        chk("rst_col", 32'(col), 32'd0);
        chk("rst_we", 32'(out_we), 32'd0);
        chk("rst_pix", 32'(out_pix), 32'd0);
        chk("rst_done", 32'(filter_done), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_we", 32'(out_we), 32'd0);
        chk("idle_done", 32'(filter_done), 32'd0);
        chk("idle_writes", 32'(nwr), 32'd0);

        fill_uniform(8'd20);
        load_image();
        run_and_check("u20");
        chk("u20_corner00", 32'(img[0][0]), 32'h007800);
        chk("u20_corner6363", 32'(img[63][63]), 32'h007800);
        chk("u20_corner063", 32'(img[0][63]), 32'h007800);
        chk("u20_corner630", 32'(img[63][0]), 32'h007800);
        chk("u20_edge_top", 32'(img[0][30]), 32'h005000);
        chk("u20_edge_right", 32'(img[30][63]), 32'h005000);
        chk("u20_interior", 32'(img[31][17]), 32'h001400);

        n0 = nwr;
        for (int i = 0; i < 10; i++) begin
            start = ~start;
            @(negedge clk);
            chk("post_done_sticky", 32'(filter_done), 32'd1);
            chk("post_done_we", 32'(out_we), 32'd0);
        end
        start = 1'b0;
        chk("post_done_no_writes", 32'(nwr), 32'(n0));

        do_reset();
        fill_uniform(8'd100);
        load_image();
        run_and_check("u100");
        chk("u100_interior", 32'(img[20][40]), 32'h006400);
        chk("u100_edge", 32'(img[63][12]), 32'h00ff00);
        chk("u100_corner", 32'(img[0][0]), 32'h00ff00);

        do_reset();
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                src[r][c] = {8'($urandom), 8'h00, 8'($urandom)};
        src[10][10] = {8'($urandom), 8'hff, 8'($urandom)};
        load_image();
        run_and_check("hot");
        chk("hot_center", 32'(img[10][10]), 32'h00ff00);
        chk("hot_nbr_ul", 32'(img[9][9]), 32'h000000);
        chk("hot_nbr_dn", 32'(img[11][10]), 32'h000000);
        chk("hot_far", 32'(img[40][40]), 32'h000000);

        do_reset();
        fill_random();
        load_image();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2999) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_row", 32'(row), 32'd0);
        chk("midrst_col", 32'(col), 32'd0);
        chk("midrst_we", 32'(out_we), 32'd0);
        chk("midrst_pix", 32'(out_pix), 32'd0);
        chk("midrst_done", 32'(filter_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n0 = nwr;
        repeat (20) @(negedge clk);
        chk("midrst_idle_writes", 32'(nwr), 32'(n0));
        chk("midrst_idle_done", 32'(filter_done), 32'd0);
        chk("midrst_idle_row", 32'(row), 32'd0);

        fill_random();
        load_image();
        run_and_check("rnd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
